mips_hazard_sb: RTL and testbench

Parametrised hazard unit for the N-lane superscalar MIPS pipeline. It generalises the dual-issue hazard logic to `LANES` issue lanes. It adds a one-entry scoreboard for a shared multi-cycle multiply/divide unit, covering RAW, WAW and structural stalls, plus a saturating stall-cycle counter. It sits beside the datapath: it reads register specifiers and control bits from the D/E/M/W stages and drives stall, flush and forwarding-mux selects.

---
 rtl/mips_hazard_pkg.sv | 34 +++
 rtl/mips_md_scoreboard.sv | 84 ++++++++
 rtl/mips_hazard_sb.sv | 133 +++++++++++++
 tb/tb_mips_hazard_sb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hazard_pkg.sv
// ---------------------------------------------------------------------------
// mips_hazard_pkg : shared forward codes, scoreboard states and helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_hazard_pkg;

  localparam int FWD_RF = 0;
  localparam int STG_E  = 0;
  localparam int STG_M  = 1;
  localparam int STG_W  = 2;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_e;

  function automatic int fwd_width(input int lanes);
    return $clog2(3 * lanes + 1);
  endfunction

  function automatic int fwd_code(input int stage, input int lane, input int lanes);
    return 1 + stage * lanes + lane;
  endfunction

  // $0 is hardwired, so it can never create a dependency
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_md_scoreboard.sv
// ---------------------------------------------------------------------------
// mips_md_scoreboard : one-entry scoreboard for the shared mult/div unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_md_scoreboard
  import mips_hazard_pkg::*;
#(
  parameter int LANES = 2,
  parameter int MDLAT = 4
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic [LANES-1:0]   multi_i,
  input  logic [LANES-1:0]   regwr_i,
  input  logic [5*LANES-1:0] rs_i,
  input  logic [5*LANES-1:0] rt_i,
  input  logic [5*LANES-1:0] wreg_i,
  input  logic               stall_i,
  output logic               busy_o,
  output logic               md_stall_o
);

  localparam int CNTW = (MDLAT > 2) ? $clog2(MDLAT) : 1;

  sb_state_e       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [4:0]      dst_q, dst_d;
  logic [4:0]      issue_dst;
  logic            issue, raw, waw;

  assign issue = (state_q == SB_IDLE) && (|multi_i) && !stall_i;

  always_comb begin
    issue_dst = 5'd0;
    raw       = 1'b0;
    waw       = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (multi_i[k]) issue_dst = wreg_i[5*k +: 5];
      if (reg_hit(dst_q, rs_i[5*k +: 5]) || reg_hit(dst_q, rt_i[5*k +: 5])) raw = 1'b1;
      if (regwr_i[k] && reg_hit(dst_q, wreg_i[5*k +: 5])) waw = 1'b1;
    end
  end

  // Leaving BUSY as the count reaches zero gives exactly MDLAT-1 busy cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    case (state_q)
      SB_IDLE: begin
        if (issue) begin
          state_d = SB_BUSY;
          cnt_d   = CNTW'(MDLAT - 1);
          dst_d   = issue_dst;
        end
      end
      SB_BUSY: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q <= CNTW'(1)) state_d = SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SB_IDLE;
      cnt_q   <= '0;
      dst_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
    end
  end

  assign busy_o     = (state_q == SB_BUSY);
  assign md_stall_o = busy_o && ((|multi_i) || raw || waw);

endmodule

`default_nettype wire

// File: rtl/mips_hazard_sb.sv
// ---------------------------------------------------------------------------
// mips_hazard_sb : N-lane hazard unit with forwarding, stalls and md scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_hazard_sb
  import mips_hazard_pkg::*;
#(
  parameter int LANES = 2,
  parameter int MDLAT = 4,
  parameter int CW    = 16,
  localparam int FS   = fwd_width(LANES),
  localparam int FD   = $clog2(LANES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5*LANES-1:0] rsD,
  input  logic [5*LANES-1:0] rtD,
  input  logic [5*LANES-1:0] WriteRegD,
  input  logic [LANES-1:0]   RegWriteD,
  input  logic [LANES-1:0]   BranchD,
  input  logic [LANES-1:0]   MultiD,
  input  logic [5*LANES-1:0] rsE,
  input  logic [5*LANES-1:0] rtE,
  input  logic [5*LANES-1:0] WriteRegE,
  input  logic [LANES-1:0]   RegWriteE,
  input  logic [LANES-1:0]   MemtoRegE,
  input  logic [5*LANES-1:0] WriteRegM,
  input  logic [5*LANES-1:0] WriteRegW,
  input  logic [LANES-1:0]   RegWriteM,
  input  logic [LANES-1:0]   MemtoRegM,
  input  logic [LANES-1:0]   RegWriteW,
  output logic               StallF,
  output logic               StallD,
  output logic               FlushE,
  output logic [FS*LANES-1:0] ForwardAE,
  output logic [FS*LANES-1:0] ForwardBE,
  output logic [FD*LANES-1:0] ForwardAD,
  output logic [FD*LANES-1:0] ForwardBD,
  output logic               MdBusy,
  output logic [CW-1:0]      StallCount
);

  logic          lwstall, brstall, mdstall, stall;
  logic [CW-1:0] cnt_q;

  // Lowest priority first, so later matches overwrite earlier ones
  for (genvar j = 0; j < LANES; j++) begin : g_fwd_e
    logic [FS-1:0] fa, fb;
    always_comb begin
      fa = FS'(FWD_RF);
      fb = FS'(FWD_RF);
      for (int i = 0; i < LANES; i++) begin
        if (RegWriteW[i] && reg_hit(WriteRegW[5*i +: 5], rsE[5*j +: 5])) fa = FS'(fwd_code(STG_W, i, LANES));
        if (RegWriteW[i] && reg_hit(WriteRegW[5*i +: 5], rtE[5*j +: 5])) fb = FS'(fwd_code(STG_W, i, LANES));
      end
      for (int i = 0; i < LANES; i++) begin
        if (RegWriteM[i] && reg_hit(WriteRegM[5*i +: 5], rsE[5*j +: 5])) fa = FS'(fwd_code(STG_M, i, LANES));
        if (RegWriteM[i] && reg_hit(WriteRegM[5*i +: 5], rtE[5*j +: 5])) fb = FS'(fwd_code(STG_M, i, LANES));
      end
      for (int i = 0; i < j; i++) begin
        if (RegWriteE[i] && reg_hit(WriteRegE[5*i +: 5], rsE[5*j +: 5])) fa = FS'(fwd_code(STG_E, i, LANES));
        if (RegWriteE[i] && reg_hit(WriteRegE[5*i +: 5], rtE[5*j +: 5])) fb = FS'(fwd_code(STG_E, i, LANES));
      end
    end
    assign ForwardAE[FS*j +: FS] = fa;
    assign ForwardBE[FS*j +: FS] = fb;
  end

  for (genvar j = 0; j < LANES; j++) begin : g_fwd_d
    logic [FD-1:0] fa, fb;
    always_comb begin
      fa = '0;
      fb = '0;
      for (int i = 0; i < LANES; i++) begin
        if (RegWriteM[i] && reg_hit(WriteRegM[5*i +: 5], rsD[5*j +: 5])) fa = FD'(i + 1);
        if (RegWriteM[i] && reg_hit(WriteRegM[5*i +: 5], rtD[5*j +: 5])) fb = FD'(i + 1);
      end
    end
    assign ForwardAD[FD*j +: FD] = fa;
    assign ForwardBD[FD*j +: FD] = fb;
  end

  always_comb begin
    lwstall = 1'b0;
    brstall = 1'b0;
    for (int e = 0; e < LANES; e++) begin
      for (int k = 0; k < LANES; k++) begin
        if (MemtoRegE[e] && (reg_hit(WriteRegE[5*e +: 5], rsD[5*k +: 5]) ||
                             reg_hit(WriteRegE[5*e +: 5], rtD[5*k +: 5])))
          lwstall = 1'b1;
        if (BranchD[k] && RegWriteE[e] && (reg_hit(WriteRegE[5*e +: 5], rsD[5*k +: 5]) ||
                                           reg_hit(WriteRegE[5*e +: 5], rtD[5*k +: 5])))
          brstall = 1'b1;
        if (BranchD[k] && MemtoRegM[e] && (reg_hit(WriteRegM[5*e +: 5], rsD[5*k +: 5]) ||
                                           reg_hit(WriteRegM[5*e +: 5], rtD[5*k +: 5])))
          brstall = 1'b1;
      end
    end
  end

  mips_md_scoreboard #(
    .LANES (LANES),
    .MDLAT (MDLAT)
  ) u_md_sb (
    .clk        (clk),
    .rst_ni     (reset),
    .multi_i    (MultiD),
    .regwr_i    (RegWriteD),
    .rs_i       (rsD),
    .rt_i       (rtD),
    .wreg_i     (WriteRegD),
    .stall_i    (stall),
    .busy_o     (MdBusy),
    .md_stall_o (mdstall)
  );

  assign stall  = lwstall | brstall | mdstall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else if (stall && (cnt_q != {CW{1'b1}})) cnt_q <= cnt_q + CW'(1);
  end

  assign StallCount = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_hazard_sb.sv
// ---------------------------------------------------------------------------
// tb_mips_hazard_sb : directed + random bench against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_hazard_sb;

  localparam int L     = 2;
  localparam int MDLAT = 4;
  localparam int CW    = 5;
  localparam int FS    = 3;
  localparam int FD    = 2;
  localparam int CMAX  = 31;

  logic clk = 1'b0;
  logic reset;
  logic [5*L-1:0] rsD, rtD, WriteRegD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic [L-1:0]   RegWriteD, BranchD, MultiD, RegWriteE, MemtoRegE;
  logic [L-1:0]   RegWriteM, MemtoRegM, RegWriteW;
  logic           StallF, StallD, FlushE, MdBusy;
  logic [FS*L-1:0] ForwardAE, ForwardBE;
  logic [FD*L-1:0] ForwardAD, ForwardBD;
  logic [CW-1:0]  StallCount;

  int n_checks = 0;
  int n_err    = 0;
  int m_left   = 0;
  int m_cnt    = 0;
  logic [4:0] m_dst = 5'd0;

  always #5 clk = ~clk;

  mips_hazard_sb #(.LANES(L), .MDLAT(MDLAT), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .WriteRegD(WriteRegD),
    .RegWriteD(RegWriteD), .BranchD(BranchD), .MultiD(MultiD),
    .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MdBusy(MdBusy), .StallCount(StallCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_fwd_e(input int j, input logic [4:0] src);
    if (src == 5'd0) return 0;
    for (int i = j - 1; i >= 0; i--)
      if (RegWriteE[i] && WriteRegE[5*i +: 5] == src) return 1 + i;
    for (int i = L - 1; i >= 0; i--)
      if (RegWriteM[i] && WriteRegM[5*i +: 5] == src) return 1 + L + i;
    for (int i = L - 1; i >= 0; i--)
      if (RegWriteW[i] && WriteRegW[5*i +: 5] == src) return 1 + 2*L + i;
    return 0;
  endfunction

  function automatic int m_fwd_d(input logic [4:0] src);
    if (src == 5'd0) return 0;
    for (int i = L - 1; i >= 0; i--)
      if (RegWriteM[i] && WriteRegM[5*i +: 5] == src) return 1 + i;
    return 0;
  endfunction

  function automatic logic uses(input int k, input logic [4:0] r);
    return (r != 5'd0) && (rsD[5*k +: 5] == r || rtD[5*k +: 5] == r);
  endfunction

  function automatic logic m_stall();
    logic s = 1'b0;
    for (int k = 0; k < L; k++) begin
      for (int e = 0; e < L; e++) begin
        if (MemtoRegE[e] && uses(k, WriteRegE[5*e +: 5])) s = 1'b1;
        if (BranchD[k] && RegWriteE[e] && uses(k, WriteRegE[5*e +: 5])) s = 1'b1;
        if (BranchD[k] && MemtoRegM[e] && uses(k, WriteRegM[5*e +: 5])) s = 1'b1;
      end
      if (m_left > 0) begin
        if (MultiD[k] || uses(k, m_dst)) s = 1'b1;
        if (RegWriteD[k] && m_dst != 5'd0 && WriteRegD[5*k +: 5] == m_dst) s = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic check_now();
    logic s;
    logic [FS*L-1:0] eae, ebe;
    logic [FD*L-1:0] ead, ebd;
    #1;
    s = m_stall();
    for (int j = 0; j < L; j++) begin
      eae[FS*j +: FS] = FS'(m_fwd_e(j, rsE[5*j +: 5]));
      ebe[FS*j +: FS] = FS'(m_fwd_e(j, rtE[5*j +: 5]));
      ead[FD*j +: FD] = FD'(m_fwd_d(rsD[5*j +: 5]));
      ebd[FD*j +: FD] = FD'(m_fwd_d(rtD[5*j +: 5]));
    end
    chk("stall", {29'd0, StallF, StallD, FlushE}, {29'd0, {3{s}}});
    chk("fwdAE", ForwardAE, eae);
    chk("fwdBE", ForwardBE, ebe);
    chk("fwdAD", ForwardAD, ead);
    chk("fwdBD", ForwardBD, ebd);
    chk("mdbusy", MdBusy, (m_left > 0));
    chk("stallcnt", StallCount, m_cnt);
  endtask

  task automatic tick();
    logic s;
    assert ($onehot0(MultiD)) else $error("more than one MultiD bit set");
    s = m_stall();
    @(posedge clk);
    if (m_left > 0) m_left--;
    else if ((|MultiD) && !s) begin
      m_left = MDLAT - 1;
      for (int k = 0; k < L; k++) if (MultiD[k]) m_dst = WriteRegD[5*k +: 5];
    end
    if (s && m_cnt != CMAX) m_cnt++;
    @(negedge clk);
  endtask

  task automatic clr();
    rsD = '0; rtD = '0; WriteRegD = '0; rsE = '0; rtE = '0; WriteRegE = '0;
    WriteRegM = '0; WriteRegW = '0; RegWriteD = '0; BranchD = '0; MultiD = '0;
    RegWriteE = '0; MemtoRegE = '0; RegWriteM = '0; MemtoRegM = '0; RegWriteW = '0;
  endtask

  task automatic set_add();
    clr();
    rsD[4:0] = 5'd9; rtD[4:0] = 5'd1; WriteRegD[4:0] = 5'd2; RegWriteD = 2'b01;
  endtask

  task automatic issue_mult9();
    clr();
    MultiD = 2'b01; RegWriteD = 2'b01; WriteRegD[4:0] = 5'd9;
    check_now();
    chk("mult_issue_nostall", StallF, 1'b0);
    tick();
  endtask

  function automatic logic [4:0] rr();
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    clr();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_now();
    chk("rst_busy", MdBusy, 1'b0);
    chk("rst_cnt", StallCount, 0);
    chk("rst_fwd", {ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 0);
    reset = 1'b1;

    // E lane 0 -> E lane 1 forwarding
    clr();
    RegWriteE[0] = 1'b1; WriteRegE[4:0] = 5'd5; rsE[9:5] = 5'd5;
    check_now();
    chk("fwdAE_l1_e0", ForwardAE[FS +: FS], 3'd1);
    chk("fwdAE_l0_rf", ForwardAE[0 +: FS], 3'd0);
    tick();

    // M lane 1 beats W lane 0
    clr();
    RegWriteM[1] = 1'b1; WriteRegM[9:5] = 5'd8;
    RegWriteW[0] = 1'b1; WriteRegW[4:0] = 5'd8; rsE[4:0] = 5'd8;
    check_now();
    chk("fwdAE_l0_m1", ForwardAE[0 +: FS], 3'd4);
    tick();

    // Load-use stall for exactly one cycle
    clr();
    MemtoRegE[1] = 1'b1; RegWriteE[1] = 1'b1; WriteRegE[9:5] = 5'd3; rtD[4:0] = 5'd3;
    check_now();
    chk("lw_stall", StallF, 1'b1);
    tick();
    clr();
    rtD[4:0] = 5'd3;
    check_now();
    chk("lw_released", StallF, 1'b0);
    chk("lw_count", StallCount, 1);
    tick();

    // Mult/div RAW and structural stalls
    issue_mult9();
    set_add();
    check_now();
    chk("md_c11_busy", MdBusy, 1'b1);
    chk("md_c11_stall", StallD, 1'b1);
    tick();
    clr();
    rsD[4:0] = 5'd1; rtD[4:0] = 5'd1; WriteRegD[4:0] = 5'd3; RegWriteD = 2'b11;
    MultiD = 2'b10; WriteRegD[9:5] = 5'd10;
    check_now();
    chk("md_c12_struct", StallD, 1'b1);
    tick();
    set_add();
    check_now();
    chk("md_c13_stall", StallD, 1'b1);
    tick();
    set_add();
    check_now();
    chk("md_c14_busy", MdBusy, 1'b0);
    chk("md_c14_stall", StallD, 1'b0);
    tick();

    // Branch stall, then decode forward from M
    clr();
    BranchD[1] = 1'b1; rsD[9:5] = 5'd4; RegWriteE[0] = 1'b1; WriteRegE[4:0] = 5'd4;
    check_now();
    chk("br_stall", StallD, 1'b1);
    tick();
    clr();
    BranchD[1] = 1'b1; rsD[9:5] = 5'd4; RegWriteM[0] = 1'b1; WriteRegM[4:0] = 5'd4;
    check_now();
    chk("br_fwdAD", ForwardAD[FD +: FD], 2'd1);
    chk("br_nostall", StallD, 1'b0);
    tick();

    // Reset in the middle of a BUSY period
    issue_mult9();
    set_add();
    check_now();
    tick();
    reset = 1'b0;
    #1;
    m_left = 0; m_dst = 5'd0; m_cnt = 0;
    chk("midrst_busy", MdBusy, 1'b0);
    chk("midrst_cnt", StallCount, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_now();
    chk("postrst_nostall", StallD, 1'b0);
    tick();

    // Saturation of the stall counter
    clr();
    MemtoRegE[0] = 1'b1; WriteRegE[4:0] = 5'd3; rsD[4:0] = 5'd3;
    for (int n = 0; n < 40; n++) begin
      check_now();
      tick();
    end
    check_now();
    chk("cnt_saturated", StallCount, CMAX);

    reset = 1'b0;
    #1;
    m_left = 0; m_dst = 5'd0; m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 400; n++) begin
      int r;
      for (int k = 0; k < L; k++) begin
        rsD[5*k +: 5] = rr(); rtD[5*k +: 5] = rr(); WriteRegD[5*k +: 5] = rr();
        rsE[5*k +: 5] = rr(); rtE[5*k +: 5] = rr(); WriteRegE[5*k +: 5] = rr();
        WriteRegM[5*k +: 5] = rr(); WriteRegW[5*k +: 5] = rr();
      end
      RegWriteD = 2'($urandom_range(0, 3));
      BranchD   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
      RegWriteE = 2'($urandom_range(0, 3));
      MemtoRegE = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
      RegWriteM = 2'($urandom_range(0, 3));
      MemtoRegM = 2'($urandom_range(0, 3)) & RegWriteM;
      RegWriteW = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 5);
      MultiD = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b00;
      check_now();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
